// File: rtl/aes_vector_checker_if.sv
// Decryptor drive/return bus between the vector checker and the core under test.
//   dut_key, dut_in_text : key and ciphertext driven to the decryptor
//   dut_valid            : high for each issue cycle
//   dut_out_text         : decryptor result returned to the checker
interface aes_vector_checker_if #(
  parameter int unsigned DATA_W = 128
);
  logic [DATA_W-1:0] dut_key;
  logic [DATA_W-1:0] dut_in_text;
  logic              dut_valid;
  logic [DATA_W-1:0] dut_out_text;

  modport master (output dut_key, output dut_in_text, output dut_valid, input dut_out_text);
  modport slave  (input dut_key, input dut_in_text, input dut_valid, output dut_out_text);
endinterface

// File: rtl/aes_vector_checker.sv
// Self-checking vector sequencer for an AES decryptor datapath.
// Holds NUM_VEC (key, ciphertext, expected) triples, issues them to the core
// back-to-back (PIPELINED=1) or one at a time (PIPELINED=0), and compares each
// result DUT_LATENCY cycles after issue.
//   clk, reset          : rising-edge clock, async active-low reset
//   start               : run request (IDLE/DONE only)
//   vec_we/addr/key/in/exp : vector memory write port (ignored while busy)
//   dut                 : master side of the decryptor bus
//   busy, done          : run status
//   pass_cnt, fail_cnt  : compare results of the current/last run
//   first_fail_idx/valid: index of the first miscompare
module aes_vector_checker #(
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned NUM_VEC     = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DUT_LATENCY = 11,
  parameter int unsigned PIPELINED   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  vec_we,
  input  logic [ADDR_W-1:0]     vec_addr,
  input  logic [DATA_W-1:0]     vec_key,
  input  logic [DATA_W-1:0]     vec_in,
  input  logic [DATA_W-1:0]     vec_exp,
  aes_vector_checker_if.master  dut,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W:0]       pass_cnt,
  output logic [ADDR_W:0]       fail_cnt,
  output logic [ADDR_W-1:0]     first_fail_idx,
  output logic                  first_fail_valid
);

  localparam int unsigned       DEPTH    = 1 << ADDR_W;
  localparam int unsigned       CNT_W    = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_VEC - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_DONE} state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   idx, idx_d;
  logic [DATA_W-1:0]   key_q, key_d, in_q, in_d, exp_q, exp_d;
  logic                valid_q, valid_d, busy_d, done_d, load;
  logic [CNT_W-1:0]    pass_d, fail_d;
  logic [ADDR_W-1:0]   ffi_d;
  logic                ffv_d, wr_en;

  logic [DATA_W-1:0]   key_mem [DEPTH];
  logic [DATA_W-1:0]   in_mem  [DEPTH];
  logic [DATA_W-1:0]   exp_mem [DEPTH];

  logic                dl_v   [DUT_LATENCY];
  logic [DATA_W-1:0]   dl_exp [DUT_LATENCY];
  logic [ADDR_W-1:0]   dl_idx [DUT_LATENCY];

  logic                cmp_fire, cmp_ok;
  logic [ADDR_W-1:0]   cmp_idx;

  assign dut.dut_key     = key_q;
  assign dut.dut_in_text = in_q;
  assign dut.dut_valid   = valid_q;

  assign wr_en    = vec_we && (state == S_IDLE || state == S_DONE);
  assign cmp_fire = dl_v[DUT_LATENCY-1];
  assign cmp_ok   = (dut.dut_out_text == dl_exp[DUT_LATENCY-1]);
  assign cmp_idx  = dl_idx[DUT_LATENCY-1];

  // Vector memory: survives reset so a rerun reuses the stored vectors.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      key_mem[vec_addr] <= vec_key;
      in_mem[vec_addr]  <= vec_in;
      exp_mem[vec_addr] <= vec_exp;
    end
  end

  // Expected-value delay line; sampled from the issue registers so the
  // tail entry lines up with the edge ending cycle issue+DUT_LATENCY.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DUT_LATENCY); i++) begin
        dl_v[i]   <= 1'b0;
        dl_exp[i] <= '0;
        dl_idx[i] <= '0;
      end
    end else begin
      dl_v[0]   <= valid_q;
      dl_exp[0] <= exp_q;
      dl_idx[0] <= idx;
      for (int i = 1; i < int'(DUT_LATENCY); i++) begin
        dl_v[i]   <= dl_v[i-1];
        dl_exp[i] <= dl_exp[i-1];
        dl_idx[i] <= dl_idx[i-1];
      end
    end
  end

  // Next-state, counter and issue-register logic.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    load    = 1'b0;
    valid_d = 1'b0;
    pass_d  = pass_cnt;
    fail_d  = fail_cnt;
    ffi_d   = first_fail_idx;
    ffv_d   = first_fail_valid;
    key_d   = key_q;
    in_d    = in_q;
    exp_d   = exp_q;

    if (cmp_fire) begin
      if (cmp_ok) begin
        pass_d = pass_cnt + CNT_W'(1);
      end else begin
        fail_d = fail_cnt + CNT_W'(1);
        if (!first_fail_valid) begin
          ffi_d = cmp_idx;
          ffv_d = 1'b1;
        end
      end
    end

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          pass_d  = '0;
          fail_d  = '0;
          ffi_d   = '0;
          ffv_d   = 1'b0;
          idx_d   = '0;
          load    = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (PIPELINED != 0) begin
          if (idx == LAST_IDX) begin
            state_d = S_DRAIN;
          end else begin
            idx_d = idx + ADDR_W'(1);
            load  = 1'b1;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cmp_fire) begin
          if (idx == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx + ADDR_W'(1);
            load    = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DRAIN: begin
        if (cmp_fire && cmp_idx == LAST_IDX) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // A write landing in the same cycle as the load is forwarded.
    if (load) begin
      valid_d = 1'b1;
      if (wr_en && vec_addr == idx_d) begin
        key_d = vec_key;
        in_d  = vec_in;
        exp_d = vec_exp;
      end else begin
        key_d = key_mem[idx_d];
        in_d  = in_mem[idx_d];
        exp_d = exp_mem[idx_d];
      end
    end

    busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      idx              <= '0;
      key_q            <= '0;
      in_q             <= '0;
      exp_q            <= '0;
      valid_q          <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass_cnt         <= '0;
      fail_cnt         <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      state            <= state_d;
      idx              <= idx_d;
      key_q            <= key_d;
      in_q             <= in_d;
      exp_q            <= exp_d;
      valid_q          <= valid_d;
      busy             <= busy_d;
      done             <= done_d;
      pass_cnt         <= pass_d;
      fail_cnt         <= fail_d;
      first_fail_idx   <= ffi_d;
      first_fail_valid <= ffv_d;
    end
  end

endmodule

// File: tb/tb_aes_vector_checker.sv
// Directed bench for aes_vector_checker: three checkers (16-vector pipelined,
// 16-vector iterative, 1-vector FIPS-197) each driving a fixed-latency
// decryptor stand-in that knows the FIPS-197 pair and otherwise returns key^ct.
module tb_aes_vector_checker;
  localparam int unsigned L = 11;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_p = 1'b0, start_s = 1'b0, start_f = 1'b0;
  logic we_p = 1'b0, we_s = 1'b0, we_f = 1'b0;
  logic [3:0]   addr = '0;
  logic [127:0] wkey = '0, win = '0, wexp = '0;

  logic       busy_p, done_p, ffv_p, busy_s, done_s, ffv_s, busy_f, done_f, ffv_f;
  logic [4:0] pass_p, fail_p, pass_s, fail_s, pass_f, fail_f;
  logic [3:0] ffi_p, ffi_s, ffi_f;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_vector_checker_if #(.DATA_W(128)) if_p ();
  aes_vector_checker_if #(.DATA_W(128)) if_s ();
  aes_vector_checker_if #(.DATA_W(128)) if_f ();

  aes_vector_checker #(.DATA_W(128), .NUM_VEC(16), .ADDR_W(4), .DUT_LATENCY(L), .PIPELINED(1)) u_p (
    .clk(clk), .reset(reset), .start(start_p), .vec_we(we_p), .vec_addr(addr),
    .vec_key(wkey), .vec_in(win), .vec_exp(wexp), .dut(if_p), .busy(busy_p), .done(done_p),
    .pass_cnt(pass_p), .fail_cnt(fail_p), .first_fail_idx(ffi_p), .first_fail_valid(ffv_p));

  aes_vector_checker #(.DATA_W(128), .NUM_VEC(16), .ADDR_W(4), .DUT_LATENCY(L), .PIPELINED(0)) u_s (
    .clk(clk), .reset(reset), .start(start_s), .vec_we(we_s), .vec_addr(addr),
    .vec_key(wkey), .vec_in(win), .vec_exp(wexp), .dut(if_s), .busy(busy_s), .done(done_s),
    .pass_cnt(pass_s), .fail_cnt(fail_s), .first_fail_idx(ffi_s), .first_fail_valid(ffv_s));

  aes_vector_checker #(.DATA_W(128), .NUM_VEC(1), .ADDR_W(4), .DUT_LATENCY(L), .PIPELINED(1)) u_f (
    .clk(clk), .reset(reset), .start(start_f), .vec_we(we_f), .vec_addr(addr),
    .vec_key(wkey), .vec_in(win), .vec_exp(wexp), .dut(if_f), .busy(busy_f), .done(done_f),
    .pass_cnt(pass_f), .fail_cnt(fail_f), .first_fail_idx(ffi_f), .first_fail_valid(ffv_f));

  function automatic logic [127:0] dec_f(input logic [127:0] k, input logic [127:0] c);
    if (k == FIPS_KEY && c == FIPS_CT) return FIPS_PT;
    return k ^ c;
  endfunction

  function automatic logic [127:0] vkey(input int i);
    logic [15:0] h;
    h = 16'(i * 3 + 1);
    return {8{h}};
  endfunction

  function automatic logic [127:0] vin(input int i);
    logic [31:0] w;
    w = 32'hA5A5_0000 | 32'(i);
    return {4{w}};
  endfunction

  // Fixed-latency decryptor stand-ins: result of cycle-t inputs appears in cycle t+L.
  logic [127:0] pipe_p [L];
  logic [127:0] pipe_s [L];
  logic [127:0] pipe_f [L];
  always @(posedge clk) begin
    pipe_p[0] <= dec_f(if_p.dut_key, if_p.dut_in_text);
    pipe_s[0] <= dec_f(if_s.dut_key, if_s.dut_in_text);
    pipe_f[0] <= dec_f(if_f.dut_key, if_f.dut_in_text);
    for (int i = 1; i < int'(L); i++) begin
      pipe_p[i] <= pipe_p[i-1];
      pipe_s[i] <= pipe_s[i-1];
      pipe_f[i] <= pipe_f[i-1];
    end
  end
  assign if_p.dut_out_text = pipe_p[L-1];
  assign if_s.dut_out_text = pipe_s[L-1];
  assign if_f.dut_out_text = pipe_f[L-1];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic peek(input int sel, output logic v, output logic b, output logic d,
                      output logic [4:0] pc, output logic [4:0] fc, output logic [3:0] fi,
                      output logic fv, output logic [127:0] k, output logic [127:0] t);
    case (sel)
      0: begin v = if_p.dut_valid; b = busy_p; d = done_p; pc = pass_p; fc = fail_p;
               fi = ffi_p; fv = ffv_p; k = if_p.dut_key; t = if_p.dut_in_text; end
      1: begin v = if_s.dut_valid; b = busy_s; d = done_s; pc = pass_s; fc = fail_s;
               fi = ffi_s; fv = ffv_s; k = if_s.dut_key; t = if_s.dut_in_text; end
      default: begin v = if_f.dut_valid; b = busy_f; d = done_f; pc = pass_f; fc = fail_f;
               fi = ffi_f; fv = ffv_f; k = if_f.dut_key; t = if_f.dut_in_text; end
    endcase
  endtask

  task automatic set_start(input int sel, input logic val);
    case (sel)
      0: start_p = val;
      1: start_s = val;
      default: start_f = val;
    endcase
  endtask

  // Starts a run on checker sel (called at a negedge) and follows it to done.
  // poke: extra starts at cycles 3/10 and a write to index 2 at cycle 5.
  // rst_at: nonzero aborts the run with reset at that cycle.
  task automatic run(input string name, input int sel, input int exp_done, input int exp_pass,
                     input int exp_fail, input int exp_ffi, input int exp_ffv,
                     input int period, input int pulses, input bit poke, input int rst_at);
    logic v, b, d, fv;
    logic [4:0] pc, fc;
    logic [3:0] fi;
    logic [127:0] k, t;
    int n, last_v, npulse;
    n = 1; last_v = 0; npulse = 0;
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    while (n <= 400) begin
      peek(sel, v, b, d, pc, fc, fi, fv, k, t);
      if (n == 1) begin
        chk({name, "_c1_valid"}, 128'(v), 128'(1));
        chk({name, "_c1_busy"}, 128'(b), 128'(1));
        chk({name, "_c1_done"}, 128'(d), 128'(0));
        chk({name, "_c1_cnts"}, 128'({pc, fc, fv}), 128'(0));
      end
      if (rst_at != 0 && n == rst_at) begin
        reset = 1'b0;
        #1;
        peek(sel, v, b, d, pc, fc, fi, fv, k, t);
        chk({name, "_rst_ctrl"}, 128'({v, b, d, fv}), 128'(0));
        chk({name, "_rst_cnts"}, 128'({pc, fc, fi}), 128'(0));
        chk({name, "_rst_key"}, k, 128'(0));
        chk({name, "_rst_text"}, t, 128'(0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        return;
      end
      if (d) break;
      if (v) begin
        if (last_v != 0) chk({name, "_valid_gap"}, 128'(n - last_v), 128'(period));
        last_v = n;
        npulse++;
      end
      if (poke) begin
        set_start(sel, (n == 3 || n == 10));
        if (n == 5) begin
          addr = 4'd2; wkey = 128'd1; win = 128'd0; wexp = 128'd0; we_p = 1'b1;
        end else begin
          we_p = 1'b0;
        end
      end
      @(negedge clk);
      n++;
    end
    chk({name, "_done_cycle"}, 128'(n), 128'(exp_done));
    chk({name, "_busy_at_done"}, 128'(b), 128'(0));
    chk({name, "_pulses"}, 128'(npulse), 128'(pulses));
    chk({name, "_pass"}, 128'(pc), 128'(exp_pass));
    chk({name, "_fail"}, 128'(fc), 128'(exp_fail));
    chk({name, "_ffi"}, 128'(fi), 128'(exp_ffi));
    chk({name, "_ffv"}, 128'(fv), 128'(exp_ffv));
  endtask

  initial begin
    logic v, b, d, fv;
    logic [4:0] pc, fc;
    logic [3:0] fi;
    logic [127:0] k, t;

    // Reset values
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      peek(s, v, b, d, pc, fc, fi, fv, k, t);
      chk("reset_ctrl", 128'({v, b, d, fv}), 128'(0));
      chk("reset_cnts", 128'({pc, fc, fi}), 128'(0));
      chk("reset_key", k, 128'(0));
    end
    reset = 1'b1;
    @(negedge clk);

    // Load 16 vectors into both 16-vector checkers; 5 and 9 get a bad expected bit 0
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      wkey = vkey(i);
      win  = vin(i);
      wexp = vkey(i) ^ vin(i);
      if (i == 5 || i == 9) wexp[0] = ~wexp[0];
      we_p = 1'b1; we_s = 1'b1;
      @(negedge clk);
    end
    we_p = 1'b0; we_s = 1'b0;

    // FIPS-197 vector; write and start land on the same edge (write forwarded)
    addr = 4'd0; wkey = FIPS_KEY; win = FIPS_CT; wexp = FIPS_PT; we_f = 1'b1;
    run("fips", 2, L + 2, 1, 0, 0, 0, 1, 1, 1'b0, 0);
    we_f = 1'b0;

    run("pipe", 0, 28, 14, 2, 5, 1, 1, 16, 1'b0, 0);
    run("iter", 1, 193, 14, 2, 5, 1, 12, 16, 1'b0, 0);
    run("abort", 0, 0, 0, 0, 0, 0, 1, 0, 1'b0, 7);
    run("rerun", 0, 28, 14, 2, 5, 1, 1, 16, 1'b0, 0);
    run("poke", 0, 28, 14, 2, 5, 1, 1, 16, 1'b1, 0);
    // Started in the DONE cycle of the previous run
    run("b2b", 0, 28, 14, 2, 5, 1, 1, 16, 1'b0, 0);
    run("b2b_iter", 1, 193, 14, 2, 5, 1, 12, 16, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_vector_checker.md
# aes_vector_checker

Synthesizable, parametrised self-checking vector sequencer for the AES decryptor datapath. It holds NUM_VEC (key, ciphertext, expected plaintext) triples in an internal vector memory. On start it drives them into the decryptor under test, either back-to-back (pipelined core) or one at a time (iterative core), and compares each result against the expected value exactly DUT_LATENCY cycles after issue. It reports pass/fail counts and the first failing index, so on-chip regression runs without file I/O.

## Interface
- DATA_W, 128: width of key, text and expected words.
- NUM_VEC, 16: vectors per run; 1..2^ADDR_W.
- ADDR_W, 4: vector index width.
- DUT_LATENCY, 11: cycles from issue to valid dut_out_text; ≥1.
- PIPELINED, 1: 1 = issue every cycle; 0 = issue the next vector only after the previous compare.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- start  in  1  run request; honoured only in IDLE or DONE.
- vec_we  in  1  vector memory write strobe; ignored while busy.
- vec_addr  in  ADDR_W  write index.
- vec_key, vec_in, vec_exp  in  DATA_W each  key, ciphertext, expected plaintext.
- dut_key, dut_in_text  out  DATA_W each  registered drive to the decryptor.
- dut_valid  out  1  high during each issue cycle.
- dut_out_text  in  DATA_W  decryptor result.
- busy  out  1  high in ISSUE/WAIT/DRAIN.
- done  out  1  run complete; held until next start or reset.
- pass_cnt, fail_cnt  out  ADDR_W+1 each  compare results of current/last run.
- first_fail_idx  out  ADDR_W  index of first miscompare.
- first_fail_valid  out  1  first_fail_idx is meaningful.

## Operation
- States: IDLE, ISSUE, WAIT (PIPELINED=0 only), DRAIN, DONE. Reset → IDLE.
- IDLE/DONE + start: clear pass_cnt, fail_cnt, first_fail_*, done; idx←0; → ISSUE.
- ISSUE: drive dut_key/dut_in_text from memory[idx], dut_valid=1, and push {vec_exp, idx} into an expected-delay line of depth DUT_LATENCY.
  - PIPELINED=1: idx increments every cycle; after idx=NUM_VEC-1 → DRAIN.
  - PIPELINED=0: one issue cycle → WAIT.
- WAIT: dut_valid=0, dut_key/dut_in_text hold their last value. On the compare edge: if idx=NUM_VEC-1 → DONE, else idx++ and → ISSUE.
- DRAIN: dut_valid=0; → DONE on the edge of the final compare.
- Compare: when a delay-line entry emerges, test dut_out_text == expected (full DATA_W). Match: pass_cnt++. Mismatch: fail_cnt++; if first_fail_valid=0, latch idx and set first_fail_valid.
- At DONE, pass_cnt + fail_cnt = NUM_VEC always.
- vec_we while busy: write dropped and memory unchanged. vec_we and start in the same IDLE cycle: the write is committed first and is seen by the run.
- start while busy: ignored.
- Reset mid-run: state aborts to IDLE. All outputs return to reset values and the delay line is flushed. Vector memory is not cleared.
- Reset values: dut_key=0, dut_in_text=0, dut_valid=0, busy=0, done=0, pass_cnt=0, fail_cnt=0, first_fail_idx=0, first_fail_valid=0.

## Timing
- Edge E0 samples start high. Cycle 1 is the first issue cycle (dut_* valid).
- A vector issued in cycle t is compared at the edge ending cycle t+DUT_LATENCY.
- PIPELINED=1: issues in cycles 1..NUM_VEC. done rises in cycle NUM_VEC+DUT_LATENCY+1.
- PIPELINED=0: issue period is DUT_LATENCY+1. done rises in cycle NUM_VEC·(DUT_LATENCY+1)+1.
- busy falls in the same cycle that done rises.
- Counters update on the compare edge and are visible the next cycle.

## Test plan
- FIPS-197 vector: key 000102…0f, in 69c4e0d86a7b0430d8cdb78070b4c55a, exp 00112233445566778899aabbccddeeff; NUM_VEC=1, real decryptor → pass_cnt=1, fail_cnt=0, done at cycle DUT_LATENCY+2.
- 16 vectors with exp of vectors 5 and 9 corrupted (bit 0 flipped), PIPELINED=1 → pass_cnt=14, fail_cnt=2, first_fail_idx=5, done at cycle 28.
- Same 16 vectors with PIPELINED=0 against the iterative core model → identical counts; dut_valid pulses spaced exactly 12 cycles apart; done at cycle 193.
- reset driven low at cycle 7 of a run → all outputs 0 immediately (asynchronous). Next start reruns from idx 0 with stored vectors intact; counts match a clean run.
- start pulsed at cycles 3 and 10 during a run, plus vec_we to index 2 while busy → no restart, memory[2] unchanged, final counts unaffected.
- Back-to-back runs: start in the DONE cycle → counters cleared, second run reproduces the first run's results exactly.
